// File: rtl/serial_mag_compare_ctrl_if.sv
// Control-path interface of the serial magnitude-compare sequencer.
// The calculator control side (master) issues start/abort with operands and
// receives busy/done and the latched compare result.
interface serial_mag_compare_ctrl_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic                   abort;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   busy;
    logic                   done;
    logic                   lt;
    logic                   gt;
    logic                   eq;
    logic                   err;

    modport master (
        output start, abort, a, b,
        input  busy, done, lt, gt, eq, err
    );

    modport slave (
        input  start, abort, a, b,
        output busy, done, lt, gt, eq, err
    );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude-compare sequencer.
// Drives one external 7485-style 4-bit cascadable comparator over a W-bit
// operand pair, one nibble per clock, least significant nibble first. The
// comparator's result for each nibble is registered and fed back as the
// cascade input of the next nibble, so the final registered cascade value is
// the full-width compare result.
module serial_mag_compare_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_mag_compare_ctrl_if.slave     bus,
    output logic [3:0]                   cmp_a,
    output logic [3:0]                   cmp_b,
    output logic                         cmp_lt_in,
    output logic                         cmp_gt_in,
    output logic                         cmp_eq_in,
    input  logic                         cmp_lt,
    input  logic                         cmp_gt,
    input  logic                         cmp_eq
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // Cascade encoding is {lt, gt, eq}; "equal so far" is the neutral seed.
    localparam logic [2:0] CASC_EQ = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NIBBLES-1:0][3:0]    a_q, b_q;
    logic [IDX_W-1:0]           idx_q;
    logic [2:0]                 casc_q;
    logic                       err_flag_q;
    logic                       lt_q, gt_q, eq_q, err_q;

    logic                       accept;
    logic [2:0]                 cmp_res;
    logic                       nib_bad;

    assign cmp_res = {cmp_lt, cmp_gt, cmp_eq};

    // A healthy comparator asserts exactly one of its three outputs.
    assign nib_bad = !((cmp_res == 3'b100) || (cmp_res == 3'b010) || (cmp_res == 3'b001));

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE, abort returns RUN to IDLE.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Comparator drive: current nibble and registered cascade while running,
    // neutral values otherwise.
    always_comb begin
        cmp_a     = 4'h0;
        cmp_b     = 4'h0;
        cmp_lt_in = CASC_EQ[2];
        cmp_gt_in = CASC_EQ[1];
        cmp_eq_in = CASC_EQ[0];
        if (state_q == S_RUN) begin
            cmp_a     = a_q[idx_q];
            cmp_b     = b_q[idx_q];
            cmp_lt_in = casc_q[2];
            cmp_gt_in = casc_q[1];
            cmp_eq_in = casc_q[0];
        end
    end

    // State, operand capture, nibble walk, cascade register and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            casc_q     <= CASC_EQ;
            err_flag_q <= 1'b0;
            lt_q       <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others regardless of statement order.
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        idx_q      <= '0;
                        casc_q     <= CASC_EQ;
                        err_flag_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    // On abort these updates are harmless: the next accept
                    // reseeds everything and the visible result is untouched.
                    casc_q <= cmp_res;
                    if (nib_bad) begin
                        err_flag_q <= 1'b1;
                    end
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    lt_q  <= casc_q[2];
                    gt_q  <= casc_q[1];
                    eq_q  <= casc_q[0];
                    err_q <= err_flag_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.lt   = lt_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Testbench for serial_mag_compare_ctrl with NIBBLES=4 (W=16).
// The external comparator is a behavioural 7485 that can be forced to return
// an illegal {lt,gt}=1,1 on the nibble whose A value is 4'hA.
module tb_serial_mag_compare_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic err;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] cmp_a, cmp_b;
    logic       cmp_lt_in, cmp_gt_in, cmp_eq_in;
    logic       cmp_lt, cmp_gt, cmp_eq;
    logic       force_en;

    int   pass_cnt;
    int   total_cnt;
    int   cyc;
    int   last_done_cyc;
    res_t last_res;
    res_t sb_q[$];

    serial_mag_compare_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    serial_mag_compare_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_lt_in (cmp_lt_in),
        .cmp_gt_in (cmp_gt_in),
        .cmp_eq_in (cmp_eq_in),
        .cmp_lt    (cmp_lt),
        .cmp_gt    (cmp_gt),
        .cmp_eq    (cmp_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 7485: nibble magnitude decides, equal nibbles pass the cascade.
    always_comb begin
        {cmp_lt, cmp_gt, cmp_eq} = 3'b001;
        if (force_en && cmp_a == 4'hA)      {cmp_lt, cmp_gt, cmp_eq} = 3'b110;
        else if (cmp_a > cmp_b)             {cmp_lt, cmp_gt, cmp_eq} = 3'b010;
        else if (cmp_a < cmp_b)             {cmp_lt, cmp_gt, cmp_eq} = 3'b100;
        else if (cmp_eq_in)                 {cmp_lt, cmp_gt, cmp_eq} = 3'b001;
        else                                {cmp_lt, cmp_gt, cmp_eq} = {cmp_lt_in, cmp_gt_in, 1'b0};
    end

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        r.lt  = (a < b);
        r.gt  = (a > b);
        r.eq  = (a == b);
        r.err = 1'b0;
        return r;
    endfunction

    // Called at a negedge; start is sampled on the following posedge.
    task automatic start_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit push, input res_t e);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
    endtask

    // Waits for done (bounded), checks its latency, then compares the result
    // visible after the done cycle against the scoreboard head.
    task automatic wait_and_score(input string name, input int skip);
        int   n;
        res_t exp_r;
        res_t got;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        last_done_cyc = cyc;
        total_cnt++;
        if (n != NIBBLES - skip)
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, NIBBLES - skip);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.done !== 1'b0)
            $display("FAIL %s done_pulse: done=%b, expected 0 one cycle later", name, bus.done);
        else pass_cnt++;
        got = {bus.lt, bus.gt, bus.eq, bus.err};
        total_cnt++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s result: scoreboard empty, got ltgteqerr=%b", name, got);
        end else begin
            exp_r = sb_q.pop_front();
            if (got !== exp_r)
                $display("FAIL %s result: got ltgteqerr=%b, expected %b", name, got, exp_r);
            else pass_cnt++;
            last_res = exp_r;
        end
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({bus.busy, bus.done, bus.lt, bus.gt, bus.eq, bus.err} !== 6'b0)
            $display("FAIL reset_outs: got busy,done,lt,gt,eq,err=%b, expected 000000",
                     {bus.busy, bus.done, bus.lt, bus.gt, bus.eq, bus.err});
        else pass_cnt++;
        total_cnt++;
        if ({cmp_a, cmp_b} !== 8'h00)
            $display("FAIL reset_cmp_ab: got %h, expected 00", {cmp_a, cmp_b});
        else pass_cnt++;
        total_cnt++;
        if ({cmp_lt_in, cmp_gt_in, cmp_eq_in} !== 3'b001)
            $display("FAIL reset_cascade: got %b, expected 001", {cmp_lt_in, cmp_gt_in, cmp_eq_in});
        else pass_cnt++;
    endtask

    task automatic test_equal();
        start_pair(16'h1234, 16'h1234, 1'b1, model(16'h1234, 16'h1234));
        total_cnt++;
        if (bus.busy !== 1'b1)
            $display("FAIL equal_busy: got busy=%b, expected 1", bus.busy);
        else pass_cnt++;
        wait_and_score("equal_1234", 0);
    endtask

    task automatic test_magnitude();
        start_pair(16'h8000, 16'h7FFF, 1'b1, model(16'h8000, 16'h7FFF));
        wait_and_score("msb_override_gt", 0);
        start_pair(16'h0001, 16'h0010, 1'b1, model(16'h0001, 16'h0010));
        wait_and_score("nibble1_lt", 0);
        start_pair(16'hFFFE, 16'hFFFF, 1'b1, model(16'hFFFE, 16'hFFFF));
        wait_and_score("lsb_only_lt", 0);
    endtask

    task automatic test_start_ignored();
        bit saw_done;
        start_pair(16'h0005, 16'h0003, 1'b1, model(16'h0005, 16'h0003));
        repeat (2) @(negedge clk);
        bus.a     = 16'h0001;
        bus.b     = 16'h0009;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_and_score("start_in_run", 3);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done)
            $display("FAIL start_queued: got extra done pulse, expected none");
        else pass_cnt++;
    endtask

    task automatic test_abort();
        bit saw_done;
        start_pair(16'h0002, 16'h0009, 1'b0, '0);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0)
            $display("FAIL abort_busy: got busy=%b, expected 0", bus.busy);
        else pass_cnt++;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done)
            $display("FAIL abort_done: got done pulse, expected none");
        else pass_cnt++;
        total_cnt++;
        if ({bus.lt, bus.gt, bus.eq, bus.err} !== last_res)
            $display("FAIL abort_hold: got ltgteqerr=%b, expected %b",
                     {bus.lt, bus.gt, bus.eq, bus.err}, last_res);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        start_pair(16'h0003, 16'h0003, 1'b0, '0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_pair(16'h00FF, 16'h0100, 1'b1, model(16'h00FF, 16'h0100));
        wait_and_score("after_reset", 0);
    endtask

    task automatic test_err();
        force_en = 1'b1;
        start_pair(16'h0A00, 16'h0A00, 1'b1, res_t'(4'b1101));
        wait_and_score("forced_err", 0);
        force_en = 1'b0;
        start_pair(16'h0A00, 16'h0A01, 1'b1, model(16'h0A00, 16'h0A01));
        wait_and_score("clean_after_err", 0);
    endtask

    task automatic test_back_to_back();
        int first_done;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.start = 1'b1;
        sb_q.push_back(model(16'h1111, 16'h2222));
        @(negedge clk);
        wait_and_score("b2b_first", 0);
        first_done = last_done_cyc;
        total_cnt++;
        if (bus.busy !== 1'b0)
            $display("FAIL b2b_idle: got busy=%b, expected 0", bus.busy);
        else pass_cnt++;
        bus.a = 16'h3333;
        bus.b = 16'h2222;
        sb_q.push_back(model(16'h3333, 16'h2222));
        @(negedge clk);
        bus.start = 1'b0;
        wait_and_score("b2b_second", 0);
        total_cnt++;
        if (last_done_cyc - first_done != NIBBLES + 2)
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d",
                     last_done_cyc - first_done, NIBBLES + 2);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        cyc           = 0;
        last_done_cyc = 0;
        last_res      = '0;
        force_en      = 1'b0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_equal();
        test_magnitude();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_err();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
